// File: rtl/apb_i2c_pkg.sv
// Shared constants and types for the APB-to-I2C bridge and its FIFOs.
package apb_i2c_pkg;

    localparam int APB_DWIDTH    = 32;
    localparam int FIFO_AWIDTH   = 4;
    localparam int FIFO_AF_LEVEL = 12;

    typedef logic [FIFO_AWIDTH:0]  fifo_level_t;
    typedef logic [APB_DWIDTH-1:0] apb_word_t;

endpackage

// File: rtl/apb_i2c_fifo_mem.sv
// 2**AWIDTH x DWIDTH register array: one synchronous write port, one asynchronous read port.
module apb_i2c_fifo_mem #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_r [(1 << AWIDTH)];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_i2c_fifo.sv
// First-word-fall-through FIFO between the APB-to-I2C bridge and the I2C core.
// Optional macro FIFO_ERR_DETECT_EN adds the sticky ERROR flag and its ERR_CLR input.
module apb_i2c_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH   = APB_DWIDTH,
    parameter int AWIDTH   = FIFO_AWIDTH,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              RD_ENA,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic [AWIDTH:0]   LEVEL
`ifdef FIFO_ERR_DETECT_EN
    ,
    output logic              ERROR,
    input  logic              ERR_CLR
`endif
);

    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_LVL = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] AF_LVL   = AF_LEVEL[AWIDTH:0];
    localparam logic [AWIDTH:0] LVL_ZERO = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH:0] LVL_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ZERO = {AWIDTH{1'b0}};
    localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [AWIDTH:0]   level_r;
    logic [AWIDTH:0]   level_next_s;
    logic              empty_r;
    logic              full_r;
    logic              afull_r;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [DWIDTH-1:0] mem_rdata_s;

    apb_i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (WR_DATA),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    // Accept decisions and next occupancy; a pop frees room for a push into a full FIFO.
    always_comb begin
        rd_acc_s     = RD_ENA && !empty_r;
        wr_acc_s     = WR_ENA && (!full_r || rd_acc_s);
        level_next_s = level_r;
        if (wr_acc_s && !rd_acc_s) begin
            level_next_s = level_r + LVL_ONE;
        end else if (rd_acc_s && !wr_acc_s) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointers, occupancy and flags; flags are registered copies of the level decode.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
            empty_r <= (level_next_s == LVL_ZERO);
            full_r  <= (level_next_s == FULL_LVL);
            afull_r <= (level_next_s >= AF_LVL);
        end
    end

    // Head word is combinational so the bridge can return it in the same APB access.
    assign RD_DATA     = empty_r ? {DWIDTH{1'b0}} : mem_rdata_s;
    assign EMPTY       = empty_r;
    assign FULL        = full_r;
    assign ALMOST_FULL = afull_r;
    assign LEVEL       = level_r;

`ifdef FIFO_ERR_DETECT_EN
    logic ovf_s;
    logic unf_s;
    logic error_r;

    // Overflow is only a push into a full FIFO that no same-cycle pop relieves.
    always_comb begin
        ovf_s = WR_ENA && full_r && !rd_acc_s;
        unf_s = RD_ENA && empty_r;
    end

    // Sticky error; a new event takes priority over a clear request.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            error_r <= 1'b0;
        end else if (ovf_s || unf_s) begin
            error_r <= 1'b1;
        end else if (ERR_CLR) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r;
        end
    end

    assign ERROR = error_r;
`endif

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Self-checking bench for apb_i2c_fifo: queue-based reference model plus directed literal checks.
module tb_apb_i2c_fifo;
    import apb_i2c_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        WR_ENA;
    logic [31:0] WR_DATA;
    logic        RD_ENA;
    logic [31:0] RD_DATA;
    logic        FULL;
    logic        EMPTY;
    logic        ALMOST_FULL;
    logic [4:0]  LEVEL;
    logic        ERR_CLR;
`ifdef FIFO_ERR_DETECT_EN
    logic        ERROR;
`endif

    apb_i2c_fifo dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .WR_ENA      (WR_ENA),
        .WR_DATA     (WR_DATA),
        .RD_ENA      (RD_ENA),
        .RD_DATA     (RD_DATA),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .LEVEL       (LEVEL)
`ifdef FIFO_ERR_DETECT_EN
        ,
        .ERROR       (ERROR),
        .ERR_CLR     (ERR_CLR)
`endif
    );

    always #5 PCLK = ~PCLK;

    int          total = 0;
    int          bad   = 0;
    bit          run   = 1'b0;
    logic [31:0] q[$];
    bit          m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of FIFO semantics on a queue.
    task automatic model_step(input bit wr, input logic [31:0] wd, input bit rd, input bit clr);
        int  n;
        bit  rdacc, wracc, ev;
        n     = q.size();
        rdacc = rd && (n != 0);
        wracc = wr && ((n != 16) || rdacc);
        ev    = (wr && (n == 16) && !rdacc) || (rd && (n == 0));
        if (rdacc) void'(q.pop_front());
        if (wracc) q.push_back(wd);
        if (ev) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic cycle(input bit wr, input logic [31:0] wd, input bit rd, input bit clr);
        WR_ENA  = wr;
        WR_DATA = wd;
        RD_ENA  = rd;
        ERR_CLR = clr;
        @(posedge PCLK);
        if (PRESET) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            model_step(wr, wd, rd, clr);
        end
        #1;
        WR_ENA  = 1'b0;
        RD_ENA  = 1'b0;
        ERR_CLR = 1'b0;
        @(negedge PCLK);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge PCLK) begin
        if (run) begin
            chk("cmp_level", {27'd0, LEVEL}, 32'(q.size()));
            chk("cmp_empty", {31'd0, EMPTY}, {31'd0, (q.size() == 0)});
            chk("cmp_full",  {31'd0, FULL},  {31'd0, (q.size() == 16)});
            chk("cmp_afull", {31'd0, ALMOST_FULL}, {31'd0, (q.size() >= 12)});
            chk("cmp_rdata", RD_DATA, (q.size() != 0) ? q[0] : 32'd0);
`ifdef FIFO_ERR_DETECT_EN
            chk("cmp_error", {31'd0, ERROR}, {31'd0, m_err});
`endif
        end
    end

    logic [31:0] last;

    initial begin
        PRESET  = 1'b1;
        WR_ENA  = 1'b0;
        WR_DATA = 32'd0;
        RD_ENA  = 1'b0;
        ERR_CLR = 1'b0;
        #1;
        chk("rst_empty", {31'd0, EMPTY}, 32'd1);
        chk("rst_level", {27'd0, LEVEL}, 32'd0);
        chk("rst_rdata", RD_DATA, 32'd0);
        chk("rst_full",  {31'd0, FULL}, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        run    = 1'b1;

        // 1: single word fall-through
        cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        chk("t1_empty", {31'd0, EMPTY}, 32'd0);
        chk("t1_level", {27'd0, LEVEL}, 32'd1);
        chk("t1_rdata", RD_DATA, 32'hA5A5_0001);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t1_empty_after_pop", {31'd0, EMPTY}, 32'd1);
        chk("t1_rdata_after_pop", RD_DATA, 32'd0);

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 10) chk("t2_af_11", {31'd0, ALMOST_FULL}, 32'd0);
            if (i == 11) chk("t2_af_12", {31'd0, ALMOST_FULL}, 32'd1);
        end
        chk("t2_full",  {31'd0, FULL}, 32'd1);
        chk("t2_level", {27'd0, LEVEL}, 32'd16);
        cycle(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
        chk("t2_level_ovf", {27'd0, LEVEL}, 32'd16);
`ifdef FIFO_ERR_DETECT_EN
        chk("t2_error", {31'd0, ERROR}, 32'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            chk("t2_pop_order", RD_DATA, 32'(i));
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("t2_empty", {31'd0, EMPTY}, 32'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);

        // 3: simultaneous push/pop while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        chk("t3_level", {27'd0, LEVEL}, 32'd16);
`ifdef FIFO_ERR_DETECT_EN
        chk("t3_error", {31'd0, ERROR}, 32'd0);
`endif
        last = 32'd0;
        for (int i = 0; i < 16; i++) begin
            last = RD_DATA;
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("t3_last", last, 32'h55);

        // 4: alternating push/pop across two pointer wraps
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            chk("t4_rdata", RD_DATA, 32'h100 + 32'(i));
            chk("t4_level", {27'd0, LEVEL}, 32'd1);
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end

        // 5: asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        chk("t5_level5", {27'd0, LEVEL}, 32'd5);
        #2;
        PRESET = 1'b1;
        #1;
        chk("t5_empty", {31'd0, EMPTY}, 32'd1);
        chk("t5_level", {27'd0, LEVEL}, 32'd0);
        chk("t5_rdata", RD_DATA, 32'd0);
        q.delete();
        m_err = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        chk("t5_push", RD_DATA, 32'h77);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // 6: underflow and error clear
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_level", {27'd0, LEVEL}, 32'd0);
`ifdef FIFO_ERR_DETECT_EN
        chk("t6_error_set", {31'd0, ERROR}, 32'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("t6_error_clr", {31'd0, ERROR}, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("t6_set_wins", {31'd0, ERROR}, 32'd1);
`endif
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_i2c_fifo.md
Name: apb_i2c_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO that sits directly downstream and upstream of the APB-to-I2C bridge.
- TX instance: consumes the bridge's WR_ENA / WRITE_DATA_ON_TX and drives TX_EMPTY back to the bridge.
- RX instance: drives READ_DATA_ON_RX and RX_EMPTY to the bridge and pops on the bridge's RD_ENA.
- The I2C core attaches to the opposite port of each instance.

Parameters:
- DWIDTH, 32, data word width; matches the APB data bus.
- AWIDTH, 4, address width; depth = 2**AWIDTH = 16 entries.
- AF_LEVEL, 12, ALMOST_FULL asserts when LEVEL >= AF_LEVEL; legal range 1..2**AWIDTH.

Ports:
- PCLK  input  1  single clock; all state updates on its rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- WR_ENA  input  1  push strobe; one push per cycle it is high.
- WR_DATA  input  DWIDTH  data pushed when WR_ENA is high.
- RD_ENA  input  1  pop strobe; the head entry is removed at the clock edge.
- RD_DATA  output  DWIDTH  current head entry (FWFT); 0 when EMPTY.
- FULL  output  1  LEVEL == 2**AWIDTH.
- EMPTY  output  1  LEVEL == 0; wired to TX_EMPTY / RX_EMPTY.
- ALMOST_FULL  output  1  LEVEL >= AF_LEVEL.
- LEVEL  output  AWIDTH+1  number of stored entries, 0..2**AWIDTH.
- ERROR  output  1  sticky overflow/underflow flag (only with FIFO_ERR_DETECT_EN).
- ERR_CLR  input  1  clears ERROR (only with FIFO_ERR_DETECT_EN).

Behaviour:
- Reset (PRESET high, asynchronous):
  - wr_ptr = rd_ptr = 0, LEVEL = 0.
  - EMPTY = 1, FULL = 0, ALMOST_FULL = 0, RD_DATA = 0, ERROR = 0.
  - Storage array is not reset.
- Reset mid-operation discards all contents immediately. The first post-reset edge behaves as from an empty FIFO.
- Pointers are AWIDTH bits and wrap modulo 2**AWIDTH. LEVEL is held in a separate AWIDTH+1 bit counter. FULL and EMPTY are decoded from LEVEL, not from pointer comparison.
- Push:
  - WR_ENA=1 and not FULL: mem[wr_ptr] <= WR_DATA, wr_ptr++, LEVEL++.
  - WR_ENA=1 and FULL, with no accepted pop in the same cycle: write is dropped; overflow event.
- Pop:
  - RD_ENA=1 and not EMPTY: rd_ptr++, LEVEL--.
  - RD_ENA=1 and EMPTY: ignored; underflow event.
- Simultaneous push and pop:
  - Neither FULL nor EMPTY: both occur, LEVEL unchanged.
  - FULL: pop and push both accepted, LEVEL stays 2**AWIDTH, no overflow.
  - EMPTY: push accepted, pop is an underflow; no bypass, the written word appears on RD_DATA next cycle.
- Latency:
  - A word written at edge N is visible on RD_DATA and EMPTY deasserts after edge N (zero-wait FWFT).
  - RD_DATA updates to the next entry right after the popping edge.
- RD_DATA is combinational from mem[rd_ptr], gated to 0 when EMPTY. This is required because the bridge passes it straight to PRDATA in the same APB access cycle.
- All status outputs derive from registered LEVEL; no combinational path from WR_ENA/RD_ENA to FULL/EMPTY.
- Pointer wrap: the 17th push after reset (with pops in between) writes address 0 again. Order is preserved across the wrap.

Optional Feature:
- Macro: FIFO_ERR_DETECT_EN.
- Defined:
  - ERROR and ERR_CLR ports exist.
  - ERROR sets on the edge after any overflow or underflow event and stays set.
  - ERR_CLR=1 clears it; if a new event coincides with ERR_CLR, set wins.
  - Intended to drive the bridge's ERROR input (becomes PSLVERR).
- Not defined:
  - ERROR and ERR_CLR ports are absent.
  - Overflow/underflow events are silently ignored; data-path behaviour is otherwise identical.

Decomposition:
- Shared package apb_i2c_pkg:
  - constants APB_DWIDTH=32, FIFO_AWIDTH=4, FIFO_AF_LEVEL=12.
  - typedef fifo_level_t (logic [FIFO_AWIDTH:0]).
  - typedef apb_word_t (logic [APB_DWIDTH-1:0]).
- One natural sub-module: apb_i2c_fifo_mem, a 2**AWIDTH x DWIDTH register array with one synchronous write port and one asynchronous read port.
- Control logic (pointers, LEVEL, flags, ERROR) stays in apb_i2c_fifo.

Test Plan:
1. Reset, then push 0xA5A5_0001 (one WR_ENA cycle) -> next cycle EMPTY=0, LEVEL=1, RD_DATA=0xA5A5_0001. Then RD_ENA one cycle -> EMPTY=1, RD_DATA=0.
2. Push 16 words 0x0..0xF -> ALMOST_FULL rises after the 12th push, FULL=1 and LEVEL=16 after the 16th. A 17th push of 0xDEAD is dropped and ERROR=1 (macro on). Popping 16 words returns 0x0..0xF in order.
3. FIFO full, WR_ENA=RD_ENA=1 with data 0x55 -> LEVEL stays 16, ERROR stays 0. After draining, the last word read is 0x55.
4. Push/pop alternating 40 words 0x100+i -> read order exact across two pointer wraps; LEVEL never exceeds 1.
5. LEVEL=5, assert PRESET asynchronously mid-cycle -> EMPTY=1, LEVEL=0, RD_DATA=0 immediately, before the next edge. A subsequent push of 0x77 reads back 0x77.
6. EMPTY, RD_ENA=1 -> LEVEL stays 0 and ERROR=1. ERR_CLR=1 for one cycle -> ERROR=0. ERR_CLR together with another empty read -> ERROR stays 1.
